// File: rtl/flex_countdown_pkg.sv
// Shared types and constants for the loadable down-counter / timer.
// Imported by flex_countdown and by anything that decodes its state.
package flex_countdown_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The count value that triggers the terminal decrement and the expired pulse.
  localparam int unsigned TERMINAL_VALUE = 1;

endpackage : flex_countdown_pkg

// File: rtl/flex_countdown.sv
// Loadable down-counter with one-cycle expired pulse and optional auto-reload.
// Counterpart to the up-counting flex counter; used for bit-period and timeout timing.
module flex_countdown
  import flex_countdown_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    expired,
  output logic                    busy
);

  localparam logic [NUM_CNT_BITS-1:0] TERM = NUM_CNT_BITS'(TERMINAL_VALUE);
  localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    expired_q, expired_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (clear) begin
      state_d = IDLE;
      count_d = ZERO;
    end else if (load) begin
      reload_d = load_val;
      if (load_val != ZERO) begin
        count_d = load_val;
        state_d = RUN;
      end else begin
        // Zero-length timer: expire immediately without entering RUN.
        count_d   = ZERO;
        state_d   = IDLE;
        expired_d = 1'b1;
      end
    end else if ((state_q == RUN) && count_enable) begin
      if (count_q == TERM) begin
        expired_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = ZERO;
          state_d = IDLE;
        end
      end else begin
        count_d = count_q - TERM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= ZERO;
      reload_q  <= ZERO;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign count_out = count_q;
  assign expired   = expired_q;
  assign busy      = (state_q == RUN);

endmodule : flex_countdown

// File: tb/tb_flex_countdown.sv
// Directed self-checking bench for flex_countdown (NUM_CNT_BITS = 4).
// Each step drives inputs just after a rising edge, then checks outputs 1ns after the next edge.
module tb_flex_countdown;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         count_enable;
  logic         auto_reload;
  logic [W-1:0] count_out;
  logic         expired;
  logic         busy;

  int testsRun;
  int testsFailed;

  flex_countdown #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .count_out    (count_out),
    .expired      (expired),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle worth of inputs, then waits past the next rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic l,
                               input logic [W-1:0] lv, input logic en, input logic ar);
    rst          = r;
    clear        = c;
    load         = l;
    load_val     = lv;
    count_enable = en;
    auto_reload  = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic expectAll(input string tag, input int cnt, input int exp, input int bsy);
    checkOutput({tag, ".count"},   32'(count_out), 32'(cnt));
    checkOutput({tag, ".expired"}, 32'(expired),   32'(exp));
    checkOutput({tag, ".busy"},    32'(busy),      32'(bsy));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    count_enable = 1'b0; auto_reload = 1'b0;
    @(posedge clk);
    #1;

    // Reset overrides a simultaneous load
    applyStimulus(1, 0, 1, 4'd5, 1, 0);
    expectAll("reset", 0, 0, 0);

    // One-shot from 3
    applyStimulus(0, 0, 1, 4'd3, 1, 0); expectAll("os.load", 3, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("os.2",    2, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("os.1",    1, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("os.0",    0, 1, 0);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("os.hold", 0, 0, 0);

    // Periodic with reload 2, then drop auto_reload before the next terminal edge
    applyStimulus(0, 0, 1, 4'd2, 1, 1); expectAll("ar.load", 2, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("ar.1a",   1, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("ar.2a",   2, 1, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("ar.1b",   1, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("ar.2b",   2, 1, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("ar.1c",   1, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("ar.end",  0, 1, 0);

    // Enable gating
    applyStimulus(0, 0, 1, 4'd4, 0, 0); expectAll("en.load", 4, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("en.3",    3, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 0, 0); expectAll("en.hold", 3, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("en.2",    2, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("en.1",    1, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("en.0",    0, 1, 0);

    // Priority: clear beats a terminal decrement
    applyStimulus(0, 0, 1, 4'd2, 0, 0); expectAll("pc.load", 2, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("pc.1",    1, 0, 1);
    applyStimulus(0, 1, 0, 4'd0, 1, 0); expectAll("pc.clr",  0, 0, 0);

    // Priority: load beats a terminal decrement
    applyStimulus(0, 0, 1, 4'd2, 0, 0); expectAll("pl.load", 2, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("pl.1",    1, 0, 1);
    applyStimulus(0, 0, 1, 4'd7, 1, 0); expectAll("pl.7",    7, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("pl.6",    6, 0, 1);

    // Clear beats a same-cycle load
    applyStimulus(0, 1, 1, 4'd9, 1, 0); expectAll("cl.both", 0, 0, 0);

    // Enable in IDLE does not underflow
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("idle.en", 0, 0, 0);

    // Maximum value counts down in 15 enables
    applyStimulus(0, 0, 1, 4'd15, 0, 0); expectAll("max.load", 15, 0, 1);
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(0, 0, 0, 4'd0, 1, 0);
      expectAll($sformatf("max.%0d", 15 - i), 15 - i, 0, 1);
    end
    applyStimulus(0, 0, 0, 4'd0, 1, 0); expectAll("max.0", 0, 1, 0);

    // Zero-length timer, single and back-to-back
    applyStimulus(0, 0, 1, 4'd0, 0, 0); expectAll("z.a",    0, 1, 0);
    applyStimulus(0, 0, 0, 4'd0, 0, 0); expectAll("z.gap",  0, 0, 0);
    applyStimulus(0, 0, 1, 4'd0, 0, 0); expectAll("z.b1",   0, 1, 0);
    applyStimulus(0, 0, 1, 4'd0, 0, 0); expectAll("z.b2",   0, 1, 0);

    // Reload value 1 in periodic mode pulses every cycle
    applyStimulus(0, 0, 1, 4'd1, 1, 1); expectAll("p1.load", 1, 0, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("p1.a",    1, 1, 1);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("p1.b",    1, 1, 1);

    // Reset at the terminal edge emits no pulse and clears everything
    applyStimulus(1, 0, 0, 4'd0, 1, 1); expectAll("rst.mid", 0, 0, 0);
    applyStimulus(0, 0, 0, 4'd0, 1, 1); expectAll("rst.after", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_flex_countdown
